// File: rtl/ad_capture_ctrl.sv
// -----------------------------------------------------------------------------
// ad_capture_ctrl
//
// Capture controller for a pipelined parallel-output ADC. It generates the ADC
// sampling clock by dividing sys_clk, registers the ADC bus once per ADC clock
// period, throws away the samples that are still working their way through the
// ADC pipeline after an enable, then averages blocks of 2^AVG_LOG2 samples. It
// also tracks the out-of-range (OTR) bit, per output block and as a sticky flag.
//
// Parameters
//   DATA_W    ADC sample width, not counting the OTR bit
//   CLK_DIV   sys_clk cycles per ADC clock period (even, >= 2)
//   PIPE_DLY  ADC pipeline depth in ADC clocks (0..15)
//   AVG_LOG2  log2 of the samples averaged per output (0..4)
//   TWOS_COMP 1 = turn the offset-binary output into two's complement
//
// Ports
//   sys_clk       single clock
//   sys_rst_n     asynchronous active-low reset
//   i_en          capture enable (level); low returns to idle next cycle
//   i_otr_clr     one-cycle clear of o_otr_sticky
//   i_adc_data    ADC bus: [DATA_W] = OTR, [DATA_W-1:0] = sample
//   o_clk_driver  ADC sampling clock (registered)
//   o_data        averaged sample, qualified by o_valid
//   o_valid       one-cycle strobe, one sys_clk after the block's last capture
//   o_otr         OTR seen anywhere in the block that produced o_data
//   o_otr_sticky  OTR seen since the last clear
//
// Build option
//   AD_CAPTURE_OTR_CLAMP_EN  when defined, a sample captured with OTR=1 is
//                            clamped to full scale before it is accumulated
//                            (all ones if its MSB is 1, all zeros otherwise).
// -----------------------------------------------------------------------------
module ad_capture_ctrl #(
   parameter int DATA_W    = 12,
   parameter int CLK_DIV   = 4,
   parameter int PIPE_DLY  = 7,
   parameter int AVG_LOG2  = 0,
   parameter int TWOS_COMP = 0
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              i_en,
   input  logic              i_otr_clr,
   input  logic [DATA_W:0]   i_adc_data,
   output logic              o_clk_driver,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_otr,
   output logic              o_otr_sticky
);

   localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int ACC_W = DATA_W + AVG_LOG2;
   localparam int BLK_W = AVG_LOG2 + 1;

   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(CLK_DIV / 2);
   localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'((1 << AVG_LOG2) - 1);
   localparam logic [3:0]       FLUSH_LAST = 4'((PIPE_DLY > 0) ? (PIPE_DLY - 1) : 0);

   // XOR mask applied to the averaged result; flipping the MSB maps offset
   // binary onto two's complement.
   localparam logic [DATA_W-1:0] MSB_FLIP =
      (TWOS_COMP != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      RUN   = 2'd2
   } state_t;

   state_t              state_reg;
   logic [CNT_W-1:0]    cnt_reg;
   logic [3:0]          flush_cnt_reg;
   logic [ACC_W-1:0]    acc_reg;
   logic [BLK_W-1:0]    blk_cnt_reg;
   logic                blk_otr_reg;
   logic [DATA_W:0]     cap_data_reg;
   logic                cap_pend_reg;
   logic                clk_drv_reg;
   logic [DATA_W-1:0]   data_reg;
   logic                valid_reg;
   logic                otr_reg;
   logic                sticky_reg;

   logic [CNT_W-1:0]    cnt_next;
   logic                capture;
   logic                sticky_set;
   logic                cap_otr;
   logic [DATA_W-1:0]   cap_sample;
   logic [DATA_W-1:0]   cap_proc;
   logic [ACC_W-1:0]    sum_next;
   logic [DATA_W-1:0]   avg_next;
   logic                blk_otr_next;

   // The divider only runs outside IDLE; the last count of each ADC period is
   // the capture edge, which lines up with the rising half of o_clk_driver
   // having been presented to the ADC for CLK_DIV/2 cycles.
   assign cnt_next = (cnt_reg == CNT_MAX) ? '0 : cnt_reg + 1'b1;
   assign capture  = (state_reg != IDLE) && (cnt_reg == CNT_MAX);

   // A capture only really happens while enabled; a capture edge that
   // coincides with i_en falling is dropped together with the block.
   assign sticky_set = capture && i_en && i_adc_data[DATA_W];

   // The captured word is processed one cycle after it was registered, which
   // is what places o_valid one sys_clk after the capture edge.
   assign cap_otr    = cap_data_reg[DATA_W];
   assign cap_sample = cap_data_reg[DATA_W-1:0];

`ifdef AD_CAPTURE_OTR_CLAMP_EN
   // Out-of-range samples are forced to the rail indicated by their MSB so an
   // overdriven input cannot wrap to a small code inside the average.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_clamp
         assign cap_proc[gi] = cap_otr ? cap_sample[DATA_W-1] : cap_sample[gi];
      end
   endgenerate
`else
   assign cap_proc = cap_sample;
`endif

   // ACC_W = DATA_W + AVG_LOG2 holds 2^AVG_LOG2 full-scale samples exactly,
   // so the running sum can never overflow.
   assign sum_next     = acc_reg + ACC_W'(cap_proc);
   assign avg_next     = sum_next[ACC_W-1:AVG_LOG2];
   assign blk_otr_next = blk_otr_reg | cap_otr;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         flush_cnt_reg <= '0;
         acc_reg       <= '0;
         blk_cnt_reg   <= '0;
         blk_otr_reg   <= 1'b0;
         cap_data_reg  <= '0;
         cap_pend_reg  <= 1'b0;
         clk_drv_reg   <= 1'b0;
         data_reg      <= '0;
         valid_reg     <= 1'b0;
         otr_reg       <= 1'b0;
         sticky_reg    <= 1'b0;
      end else begin
         valid_reg <= 1'b0;

         // Set has priority so an OTR captured in the clear cycle is not lost.
         if (sticky_set) begin
            sticky_reg <= 1'b1;
         end else if (i_otr_clr) begin
            sticky_reg <= 1'b0;
         end

         if (!i_en) begin
            // Disable from any state: park the divider and drop the partial
            // block. o_data / o_otr keep the last completed block.
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            flush_cnt_reg <= '0;
            acc_reg       <= '0;
            blk_cnt_reg   <= '0;
            blk_otr_reg   <= 1'b0;
            cap_pend_reg  <= 1'b0;
            clk_drv_reg   <= 1'b0;
         end else begin
            // Fold in the sample registered on the previous capture edge.
            if (cap_pend_reg) begin
               cap_pend_reg <= 1'b0;
               if (blk_cnt_reg == BLK_LAST) begin
                  data_reg    <= avg_next ^ MSB_FLIP;
                  otr_reg     <= blk_otr_next;
                  valid_reg   <= 1'b1;
                  acc_reg     <= '0;
                  blk_cnt_reg <= '0;
                  blk_otr_reg <= 1'b0;
               end else begin
                  acc_reg     <= sum_next;
                  blk_cnt_reg <= blk_cnt_reg + 1'b1;
                  blk_otr_reg <= blk_otr_next;
               end
            end

            case (state_reg)
               IDLE: begin
                  cnt_reg       <= '0;
                  clk_drv_reg   <= 1'b0;
                  flush_cnt_reg <= '0;
                  state_reg     <= (PIPE_DLY == 0) ? RUN : FLUSH;
               end

               FLUSH: begin
                  cnt_reg     <= cnt_next;
                  clk_drv_reg <= (cnt_next >= CNT_HALF);
                  if (capture) begin
                     // Samples here were converted before the enable and are
                     // still leaving the ADC pipeline; count and discard them.
                     cap_data_reg <= i_adc_data;
                     if (flush_cnt_reg == FLUSH_LAST) begin
                        flush_cnt_reg <= '0;
                        state_reg     <= RUN;
                     end else begin
                        flush_cnt_reg <= flush_cnt_reg + 1'b1;
                     end
                  end
               end

               RUN: begin
                  cnt_reg     <= cnt_next;
                  clk_drv_reg <= (cnt_next >= CNT_HALF);
                  if (capture) begin
                     cap_data_reg <= i_adc_data;
                     cap_pend_reg <= 1'b1;
                  end
               end

               default: begin
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

   assign o_clk_driver = clk_drv_reg;
   assign o_data       = data_reg;
   assign o_valid      = valid_reg;
   assign o_otr        = otr_reg;
   assign o_otr_sticky = sticky_reg;

endmodule
